// File: rtl/data_memory_sync_if.sv
// Request/response bundle between the CPU data port and data_memory_sync.
// The CPU side drives requests and the external input value. The memory side
// returns registered read data, status flags and the output port register.
interface data_memory_sync_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                  RD_i;
  logic                  WR_i;
  logic [ADDR_WIDTH-1:0] ADDR_dm_i;
  logic [WORD_WIDTH-1:0] IN_DATA_i;
  logic [WORD_WIDTH-1:0] IO_IN_i;
  logic [WORD_WIDTH-1:0] OUT_DATA_o;
  logic                  VALID_o;
  logic                  READY_o;
  logic                  ERR_o;
  logic [WORD_WIDTH-1:0] IO_OUT_o;

  modport master (
    output RD_i, WR_i, ADDR_dm_i, IN_DATA_i, IO_IN_i,
    input  OUT_DATA_o, VALID_o, READY_o, ERR_o, IO_OUT_o
  );

  modport slave (
    input  RD_i, WR_i, ADDR_dm_i, IN_DATA_i, IO_IN_i,
    output OUT_DATA_o, VALID_o, READY_o, ERR_o, IO_OUT_o
  );
endinterface

// File: rtl/data_memory_sync.sv
// Synchronous data memory for the BIP datapath.
// After reset, a CLEAR pass zeroes every RAM word, one word per cycle. The
// block then enters RUN. RUN decodes RAM, an output port register and a
// sampled input port. Reads are registered with one cycle of latency. When a
// read and a write hit the same address in one cycle, the read returns the
// new data. Any access outside the decoded map sets a sticky error flag.
module data_memory_sync #(
  parameter int WORD_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 11,
  parameter int MEM_DEPTH   = 1024,
  parameter int IO_OUT_ADDR = 1024,
  parameter int IO_IN_ADDR  = 1025
) (
  input  logic            CLK_i,
  input  logic            RST_N_i,
  data_memory_sync_if.slave bus
);

  localparam int                    IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OUT_A    = ADDR_WIDTH'(IO_OUT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] IN_A     = ADDR_WIDTH'(IO_IN_ADDR);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [IDX_W-1:0]      clr_cnt_r, clr_cnt_nxt_s;
  logic                  clr_we_s;
  logic                  run_s;

  logic [WORD_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];

  logic [WORD_WIDTH-1:0] out_data_r;
  logic                  valid_r;
  logic                  ready_r;
  logic                  err_r;
  logic [WORD_WIDTH-1:0] io_out_r;
  logic [WORD_WIDTH-1:0] io_in_r;

  logic [IDX_W-1:0]      ram_idx_s;
  logic                  is_ram_s, is_out_s, is_in_s, is_oor_s;
  logic                  ram_we_s, io_out_we_s, err_set_s;
  logic [WORD_WIDTH-1:0] rd_data_s;

  // FSM state and clear-address counter
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state_r   <= CLEAR;
      clr_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next state: sweep every RAM word in CLEAR, then stay in RUN until reset
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    clr_we_s      = 1'b0;
    run_s         = 1'b0;
    case (state_r)
      CLEAR: begin
        clr_we_s = 1'b1;
        if (clr_cnt_r == LAST_IDX) begin
          state_nxt_s   = RUN;
          clr_cnt_nxt_s = '0;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + IDX_W'(1);
        end
      end
      RUN: begin
        run_s = 1'b1;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_cnt_nxt_s = '0;
      end
    endcase
  end

  // Address decode, write enables and write-first read-data selection
  always_comb begin
    ram_idx_s   = bus.ADDR_dm_i[IDX_W-1:0];
    is_ram_s    = ({1'b0, bus.ADDR_dm_i} < DEPTH_A);
    is_out_s    = (bus.ADDR_dm_i == OUT_A);
    is_in_s     = (bus.ADDR_dm_i == IN_A);
    is_oor_s    = !(is_ram_s || is_out_s || is_in_s);
    ram_we_s    = 1'b0;
    io_out_we_s = 1'b0;
    err_set_s   = 1'b0;
    rd_data_s   = '0;
    if (run_s) begin
      ram_we_s    = bus.WR_i && is_ram_s;
      io_out_we_s = bus.WR_i && is_out_s;
      err_set_s   = (bus.WR_i || bus.RD_i) && is_oor_s;
      if (is_ram_s) begin
        rd_data_s = bus.WR_i ? bus.IN_DATA_i : mem_r[ram_idx_s];
      end else if (is_out_s) begin
        rd_data_s = bus.WR_i ? bus.IN_DATA_i : io_out_r;
      end else if (is_in_s) begin
        rd_data_s = io_in_r;
      end else begin
        rd_data_s = '0;
      end
    end else begin
      rd_data_s = '0;
    end
  end

  // RAM array: clear writes take priority, then CPU writes in RUN
  always_ff @(posedge CLK_i) begin
    if (clr_we_s) begin
      mem_r[clr_cnt_r] <= '0;
    end else if (ram_we_s) begin
      mem_r[ram_idx_s] <= bus.IN_DATA_i;
    end
  end

  // Registered outputs, sticky error flag and input-port sampler
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      out_data_r <= '0;
      valid_r    <= 1'b0;
      ready_r    <= 1'b0;
      err_r      <= 1'b0;
      io_out_r   <= '0;
      io_in_r    <= '0;
    end else begin
      io_in_r <= bus.IO_IN_i;
      ready_r <= (state_nxt_s == RUN);
      valid_r <= run_s && bus.RD_i;
      err_r   <= err_r || err_set_s;
      if (run_s && bus.RD_i) begin
        out_data_r <= rd_data_s;
      end
      if (io_out_we_s) begin
        io_out_r <= bus.IN_DATA_i;
      end
    end
  end

  assign bus.OUT_DATA_o = out_data_r;
  assign bus.VALID_o    = valid_r;
  assign bus.READY_o    = ready_r;
  assign bus.ERR_o      = err_r;
  assign bus.IO_OUT_o   = io_out_r;

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync (MEM_DEPTH=8).
// Each driven read pushes its expected data to a queue. The queue is popped
// and compared when the registered result appears one edge later.
module tb_data_memory_sync;

  localparam int WW  = 16;
  localparam int AW  = 11;
  localparam int MD  = 8;
  localparam int OUT_ADDR = 1024;
  localparam int IN_ADDR  = 1025;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  data_memory_sync_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  data_memory_sync #(
    .WORD_WIDTH (WW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (MD),
    .IO_OUT_ADDR(OUT_ADDR),
    .IO_IN_ADDR (IN_ADDR)
  ) dut (
    .CLK_i  (clk),
    .RST_N_i(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [WW-1:0] mem_m [MD];
  logic [WW-1:0] io_out_m;
  logic [WW-1:0] io_in_m;
  logic [WW-1:0] last_out_m;
  logic          err_m;
  logic [WW-1:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MD; i++) mem_m[i] = '0;
    io_out_m   = '0;
    io_in_m    = '0;
    last_out_m = '0;
    err_m      = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out"},   32'(bus.OUT_DATA_o), 32'h0);
    check_val({tag, "_valid"}, 32'(bus.VALID_o),    32'h0);
    check_val({tag, "_ready"}, 32'(bus.READY_o),    32'h0);
    check_val({tag, "_err"},   32'(bus.ERR_o),      32'h0);
    check_val({tag, "_ioout"}, 32'(bus.IO_OUT_o),   32'h0);
  endtask

  // One RUN-state cycle: drive, model, then compare after the edge
  task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                       input logic [WW-1:0] data, input string tag);
    logic [WW-1:0] exp;
    logic is_ram, is_out, is_in;
    @(negedge clk);
    bus.RD_i      = rd;
    bus.WR_i      = wr;
    bus.ADDR_dm_i = addr;
    bus.IN_DATA_i = data;
    is_ram = (int'(addr) < MD);
    is_out = (int'(addr) == OUT_ADDR);
    is_in  = (int'(addr) == IN_ADDR);
    if (rd) begin
      if (is_ram)      exp = wr ? data : mem_m[addr[2:0]];
      else if (is_out) exp = wr ? data : io_out_m;
      else if (is_in)  exp = io_in_m;
      else             exp = '0;
      exp_q.push_back(exp);
    end
    if (wr && is_ram) mem_m[addr[2:0]] = data;
    if (wr && is_out) io_out_m = data;
    if ((rd || wr) && !(is_ram || is_out || is_in)) err_m = 1'b1;
    io_in_m = bus.IO_IN_i;
    @(posedge clk);
    #1;
    check_val({tag, "_valid"}, 32'(bus.VALID_o), 32'(rd));
    if (rd) begin
      check_val({tag, "_sbq"}, 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) last_out_m = exp_q.pop_front();
    end
    check_val({tag, "_data"},  32'(bus.OUT_DATA_o), 32'(last_out_m));
    check_val({tag, "_err"},   32'(bus.ERR_o),      32'(err_m));
    check_val({tag, "_ioout"}, 32'(bus.IO_OUT_o),   32'(io_out_m));
    check_val({tag, "_ready"}, 32'(bus.READY_o),    32'h1);
  endtask

  task automatic idle(input string tag);
    do_op(1'b0, 1'b0, '0, '0, tag);
  endtask

  // Wait out a full clear after reset release, checking READY timing
  task automatic wait_clear(input string tag);
    for (int i = 1; i <= MD; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("%s_ready%0d", tag, i), 32'(bus.READY_o), 32'(i == MD));
      check_val($sformatf("%s_valid%0d", tag, i), 32'(bus.VALID_o), 32'h0);
      check_val($sformatf("%s_err%0d", tag, i),   32'(bus.ERR_o),   32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int sel;
    bus.RD_i      = 1'b0;
    bus.WR_i      = 1'b0;
    bus.ADDR_dm_i = '0;
    bus.IN_DATA_i = '0;
    bus.IO_IN_i   = '0;
    model_reset();

    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clr");

    for (int i = 0; i < MD; i++) do_op(1'b1, 1'b0, AW'(i), '0, $sformatf("rd0_%0d", i));

    do_op(1'b0, 1'b1, AW'(5), 16'hBEEF, "wr5");
    do_op(1'b1, 1'b0, AW'(5), '0, "rd5");
    do_op(1'b1, 1'b0, AW'(4), '0, "rd4");
    idle("hold");

    do_op(1'b1, 1'b1, AW'(3), 16'h1234, "rw3");
    do_op(1'b1, 1'b0, AW'(3), '0, "rd3");

    do_op(1'b0, 1'b1, AW'(OUT_ADDR), 16'h00A5, "wrio");
    bus.IO_IN_i = 16'h5A5A;
    idle("ioin_wait");
    do_op(1'b1, 1'b0, AW'(IN_ADDR), '0, "rdioin");
    do_op(1'b1, 1'b0, AW'(OUT_ADDR), '0, "rdioout");
    do_op(1'b1, 1'b1, AW'(OUT_ADDR), 16'h7E57, "rwioout");
    do_op(1'b0, 1'b1, AW'(IN_ADDR), 16'hDEAD, "wrioin");

    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(0, 9));
      a = (sel < MD) ? AW'(sel) : ((sel == 8) ? AW'(OUT_ADDR) : AW'(IN_ADDR));
      if ($urandom_range(0, 3) == 0) bus.IO_IN_i = WW'($urandom());
      do_op(1'($urandom()), 1'($urandom()), a, WW'($urandom()), $sformatf("rnd%0d", n));
    end

    do_op(1'b1, 1'b0, AW'(2000), '0, "rdoor");
    do_op(1'b0, 1'b1, AW'(2000), 16'h1111, "wroor");
    for (int i = 0; i < MD; i++) do_op(1'b1, 1'b0, AW'(i), '0, $sformatf("rdchk_%0d", i));

    do_op(1'b0, 1'b1, AW'(0), 16'hFFFF, "wrff");
    @(negedge clk);
    bus.RD_i = 1'b0;
    bus.WR_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstrun");
    model_reset();

    @(negedge clk);
    rst_n         = 1'b1;
    bus.RD_i      = 1'b1;
    bus.WR_i      = 1'b1;
    bus.ADDR_dm_i = '0;
    bus.IN_DATA_i = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("midclr_valid%0d", i), 32'(bus.VALID_o), 32'h0);
      check_val($sformatf("midclr_ready%0d", i), 32'(bus.READY_o), 32'h0);
      check_val($sformatf("midclr_err%0d", i),   32'(bus.ERR_o),   32'h0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstclr");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.ADDR_dm_i = AW'(2000);
    wait_clear("reclr");
    io_in_m = bus.IO_IN_i;

    do_op(1'b1, 1'b0, AW'(0), '0, "post_rd0");
    do_op(1'b1, 1'b0, AW'(5), '0, "post_rd5");
    do_op(1'b1, 1'b0, AW'(IN_ADDR), '0, "post_rdin");
    idle("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
